// File: rtl/seq_detect_param.sv
// Parametrised Mealy serial-pattern detector with loadable pattern,
// overlap control, input qualifier and saturating match counter.
module seq_detect_param #(
   parameter int                PAT_W   = 4,
   parameter logic [PAT_W-1:0]  PAT_RST = 4'b1101,
   parameter int                CNT_W   = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic             in,
   input  logic             pat_load,
   input  logic [PAT_W-1:0] pat_in,
   input  logic             overlap,
   output logic             z,
   output logic [PAT_W-1:0] hist,
   output logic [CNT_W-1:0] match_cnt,
   output logic             cnt_sat
);

   localparam int FW = (PAT_W > 2) ? $clog2(PAT_W) : 1;
   localparam logic [FW-1:0] FILL_MAX = FW'(PAT_W - 1);

   logic [PAT_W-1:0] pat_q, pat_d;
   logic [PAT_W-1:0] hist_q, hist_d;
   logic [FW-1:0]    fill_q, fill_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [PAT_W-1:0] shift;
   logic             armed;

   assign shift   = {hist_q[PAT_W-2:0], in};
   assign armed   = (fill_q == FILL_MAX);
   assign z       = rst & ~pat_load & in_valid & armed & (shift == pat_q);
   assign hist    = hist_q;
   assign match_cnt = cnt_q;
   assign cnt_sat = &cnt_q;

   always_comb begin
      pat_d  = pat_q;
      hist_d = hist_q;
      fill_d = fill_q;
      cnt_d  = cnt_q;
      if (pat_load) begin
         pat_d  = pat_in;
         hist_d = '0;
         fill_d = '0;
         cnt_d  = '0;
      end else if (in_valid) begin
         hist_d = shift;
         if (z) begin
            // Non-overlap needs a full fresh window before re-arming
            if (!overlap) fill_d = '0;
            if (!cnt_sat) cnt_d = cnt_q + CNT_W'(1);
         end else if (!armed) begin
            fill_d = fill_q + FW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         pat_q  <= PAT_RST;
         hist_q <= '0;
         fill_q <= '0;
         cnt_q  <= '0;
      end else begin
         pat_q  <= pat_d;
         hist_q <= hist_d;
         fill_q <= fill_d;
         cnt_q  <= cnt_d;
      end
   end

endmodule

// File: tb/tb_seq_detect_param.sv
// Directed bench for seq_detect_param: default instance plus a
// narrow-counter instance with an all-ones pattern.
module tb_seq_detect_param;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic       in;
   logic       pat_load;
   logic [3:0] pat_in;
   logic       overlap;

   logic       z, z2;
   logic [3:0] hist, hist2;
   logic [7:0] match_cnt;
   logic [1:0] match_cnt2;
   logic       cnt_sat, cnt_sat2;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   seq_detect_param dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in(in),
      .pat_load(pat_load), .pat_in(pat_in), .overlap(overlap),
      .z(z), .hist(hist), .match_cnt(match_cnt), .cnt_sat(cnt_sat)
   );

   seq_detect_param #(.PAT_W(4), .PAT_RST(4'b1111), .CNT_W(2)) dut2 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in(in),
      .pat_load(pat_load), .pat_in(pat_in), .overlap(overlap),
      .z(z2), .hist(hist2), .match_cnt(match_cnt2), .cnt_sat(cnt_sat2)
   );

   // Drive one cycle of inputs; outputs settle before the next edge.
   task automatic apply(input logic v, input logic b);
      @(negedge clk);
      in_valid = v;
      in       = b;
      pat_load = 1'b0;
      #2;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst      = 1'b0;
      in_valid = 1'b0;
      pat_load = 1'b0;
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst = 1'b0; in_valid = 1'b1; in = 1'b1; pat_load = 1'b0;
      #2;
      n_checks++;
      if (z !== 1'b0) begin
         n_errors++; $display("FAIL rst_z: got %b want 0", z);
      end
      tick();
      n_checks++;
      if (hist !== 4'b0000 || match_cnt !== 8'd0 || cnt_sat !== 1'b0) begin
         n_errors++;
         $display("FAIL rst_state: hist %b cnt %0d sat %b want 0000 0 0",
                  hist, match_cnt, cnt_sat);
      end
      @(negedge clk);
      rst = 1'b1; in_valid = 1'b0;
   endtask

   task automatic test_overlap();
      logic [6:0] bits = 7'b1101101;
      logic [6:0] exp  = 7'b0001001;
      do_reset();
      overlap = 1'b1;
      for (int i = 0; i < 7; i++) begin
         apply(1'b1, bits[6-i]);
         n_checks++;
         if (z !== exp[6-i]) begin
            n_errors++;
            $display("FAIL ovl_z bit%0d: got %b want %b", i+1, z, exp[6-i]);
         end
      end
      tick();
      n_checks++;
      if (match_cnt !== 8'd2 || hist !== 4'b1101) begin
         n_errors++;
         $display("FAIL ovl_end: cnt %0d hist %b want 2 1101", match_cnt, hist);
      end
   endtask

   task automatic test_non_overlap();
      logic [6:0] bits = 7'b1101101;
      logic [6:0] exp  = 7'b0001000;
      do_reset();
      overlap = 1'b0;
      for (int i = 0; i < 7; i++) begin
         apply(1'b1, bits[6-i]);
         n_checks++;
         if (z !== exp[6-i]) begin
            n_errors++;
            $display("FAIL novl_z bit%0d: got %b want %b", i+1, z, exp[6-i]);
         end
      end
      tick();
      n_checks++;
      if (match_cnt !== 8'd1) begin
         n_errors++; $display("FAIL novl_cnt: got %0d want 1", match_cnt);
      end
      overlap = 1'b1;
   endtask

   task automatic test_valid_gap();
      do_reset();
      overlap = 1'b1;
      apply(1'b1, 1'b1);
      apply(1'b1, 1'b1);
      apply(1'b1, 1'b0);
      for (int i = 0; i < 3; i++) begin
         apply(1'b0, 1'b1);
         n_checks++;
         if (z !== 1'b0) begin
            n_errors++; $display("FAIL gap_z cyc%0d: got %b want 0", i, z);
         end
      end
      apply(1'b1, 1'b1);
      n_checks++;
      if (z !== 1'b1) begin
         n_errors++; $display("FAIL gap_final_z: got %b want 1", z);
      end
      tick();
      n_checks++;
      if (match_cnt !== 8'd1) begin
         n_errors++; $display("FAIL gap_cnt: got %0d want 1", match_cnt);
      end
   endtask

   task automatic test_pat_load();
      logic [6:0] bits = 7'b0110110;
      logic [6:0] exp  = 7'b0001001;
      @(negedge clk);
      pat_load = 1'b1; pat_in = 4'b0110; in_valid = 1'b1; in = 1'b1;
      #2;
      n_checks++;
      if (z !== 1'b0) begin
         n_errors++; $display("FAIL load_z: got %b want 0", z);
      end
      tick();
      n_checks++;
      if (hist !== 4'b0000 || match_cnt !== 8'd0) begin
         n_errors++;
         $display("FAIL load_state: hist %b cnt %0d want 0000 0", hist, match_cnt);
      end
      for (int i = 0; i < 7; i++) begin
         apply(1'b1, bits[6-i]);
         n_checks++;
         if (z !== exp[6-i]) begin
            n_errors++;
            $display("FAIL load_z bit%0d: got %b want %b", i+1, z, exp[6-i]);
         end
      end
      tick();
      n_checks++;
      if (match_cnt !== 8'd2) begin
         n_errors++; $display("FAIL load_cnt: got %0d want 2", match_cnt);
      end
   endtask

   task automatic test_zero_pattern();
      logic [4:0] exp = 5'b00011;
      @(negedge clk);
      pat_load = 1'b1; pat_in = 4'b0000; in_valid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         apply(1'b1, 1'b0);
         n_checks++;
         if (z !== exp[4-i]) begin
            n_errors++;
            $display("FAIL zero_z bit%0d: got %b want %b", i+1, z, exp[4-i]);
         end
      end
      tick();
      n_checks++;
      if (match_cnt !== 8'd2) begin
         n_errors++; $display("FAIL zero_cnt: got %0d want 2", match_cnt);
      end
   endtask

   task automatic test_saturate();
      logic [6:0] exp = 7'b0001111;
      do_reset();
      overlap = 1'b1;
      for (int i = 0; i < 7; i++) begin
         apply(1'b1, 1'b1);
         n_checks++;
         if (z2 !== exp[6-i]) begin
            n_errors++;
            $display("FAIL sat_z bit%0d: got %b want %b", i+1, z2, exp[6-i]);
         end
         if (i == 4) begin
            tick();
            n_checks++;
            if (match_cnt2 !== 2'd2 || cnt_sat2 !== 1'b0) begin
               n_errors++;
               $display("FAIL sat_mid: cnt %0d sat %b want 2 0",
                        match_cnt2, cnt_sat2);
            end
         end
         if (i == 5) begin
            tick();
            n_checks++;
            if (match_cnt2 !== 2'd3 || cnt_sat2 !== 1'b1) begin
               n_errors++;
               $display("FAIL sat_full: cnt %0d sat %b want 3 1",
                        match_cnt2, cnt_sat2);
            end
         end
      end
      tick();
      n_checks++;
      if (match_cnt2 !== 2'd3 || cnt_sat2 !== 1'b1) begin
         n_errors++;
         $display("FAIL sat_hold: cnt %0d sat %b want 3 1", match_cnt2, cnt_sat2);
      end
   endtask

   task automatic test_reset_mid();
      logic [3:0] bits = 4'b1101;
      logic [3:0] exp  = 4'b0001;
      do_reset();
      overlap = 1'b1;
      apply(1'b1, 1'b1);
      apply(1'b1, 1'b1);
      apply(1'b1, 1'b0);
      @(negedge clk);
      rst = 1'b0; in_valid = 1'b1; in = 1'b1;
      #2;
      n_checks++;
      if (z !== 1'b0) begin
         n_errors++; $display("FAIL mid_rst_z: got %b want 0", z);
      end
      tick();
      n_checks++;
      if (match_cnt !== 8'd0 || hist !== 4'b0000) begin
         n_errors++;
         $display("FAIL mid_rst_state: cnt %0d hist %b want 0 0000", match_cnt, hist);
      end
      @(negedge clk);
      rst = 1'b1; in_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         apply(1'b1, bits[3-i]);
         n_checks++;
         if (z !== exp[3-i]) begin
            n_errors++;
            $display("FAIL mid_z bit%0d: got %b want %b", i+1, z, exp[3-i]);
         end
      end
   endtask

   initial begin
      rst = 1'b0; in_valid = 1'b0; in = 1'b0;
      pat_load = 1'b0; pat_in = 4'b0000; overlap = 1'b1;
      repeat (2) @(posedge clk);
      test_reset();
      test_overlap();
      test_non_overlap();
      test_valid_gap();
      test_pat_load();
      test_zero_pattern();
      test_saturate();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
